// File: rtl/pce_audio_mix_sched_pkg.sv
// Shared types and constants for the PC Engine audio mixer scheduler.
package pce_audio_pkg;

  typedef logic signed [15:0] sample_t;
  typedef logic [8:0]         vol_t;

  typedef enum logic [1:0] {
    SRC_CDDA  = 2'd0,
    SRC_ADPCM = 2'd1,
    SRC_PSG   = 2'd2
  } src_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LATCH = 3'd1,
    ST_MUL   = 3'd2,
    ST_ACC   = 3'd3,
    ST_SAT   = 3'd4
  } state_t;

  // 19-bit accumulators hold 3 x 32768 per channel without wrapping.
  localparam int ACC_W  = 19;
  localparam int PROD_W = 26;

  localparam logic signed [ACC_W-1:0] ACC_MAX = 19'sd32767;
  localparam logic signed [ACC_W-1:0] ACC_MIN = -19'sd32768;

  // Clamp an accumulator to the 16-bit signed output range.
  function automatic sample_t sat16(input logic signed [ACC_W-1:0] a);
    if (a > ACC_MAX) begin
      return 16'sh7fff;
    end else if (a < ACC_MIN) begin
      return 16'sh8000;
    end else begin
      return a[15:0];
    end
  endfunction

endpackage

// File: rtl/pce_audio_mix_sched_if.sv
// Bus bundle between the audio sources/host and the mixer scheduler.
//
// Handshake: sample_strobe is a one-cycle request. It is accepted only in a
// cycle where busy is low; a strobe seen while busy is high is dropped and
// latches the sticky overrun flag. out_valid pulses for exactly one cycle and
// audio_l/audio_r carry the new pair in that cycle and hold it afterwards.
// busy is high from the cycle after acceptance through the out_valid cycle.
interface pce_audio_mix_sched_if;
  import pce_audio_pkg::*;

  logic    sample_strobe;
  sample_t cdda_l;
  sample_t cdda_r;
  sample_t adpcm;
  sample_t psg_l;
  sample_t psg_r;
  logic    vol_we;
  logic [1:0] vol_sel;
  vol_t    vol_data;
  logic    mute;
  sample_t audio_l;
  sample_t audio_r;
  logic    out_valid;
  logic    busy;
  logic    overrun;
  state_t  state;

  modport master (
    output sample_strobe, cdda_l, cdda_r, adpcm, psg_l, psg_r,
    output vol_we, vol_sel, vol_data, mute,
    input  audio_l, audio_r, out_valid, busy, overrun, state
  );

  modport slave (
    input  sample_strobe, cdda_l, cdda_r, adpcm, psg_l, psg_r,
    input  vol_we, vol_sel, vol_data, mute,
    output audio_l, audio_r, out_valid, busy, overrun, state
  );

endinterface

// File: rtl/pce_audio_mix_sched_vol_ramp.sv
// One per-source volume: holds the target and walks the current value one
// LSB toward the effective target (0 while muted) on each step pulse.
module pce_audio_vol_ramp
  import pce_audio_pkg::*;
#(
  parameter int UNITY = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic we,
  input  vol_t wdata,
  input  logic mute,
  input  logic step,
  output vol_t cur
);

  localparam vol_t UNITY_V = vol_t'(UNITY);

  vol_t tgt_q;
  vol_t cur_q;
  vol_t eff;

  // Effective target: mute forces a fade to silence without losing the target.
  always_comb begin
    eff = mute ? '0 : tgt_q;
  end

  // Target register, clamped so gain never exceeds unity.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tgt_q <= UNITY_V;
    end else if (we) begin
      tgt_q <= (wdata > UNITY_V) ? UNITY_V : wdata;
    end
  end

  // Current volume moves one LSB per step toward the effective target.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_q <= UNITY_V;
    end else if (step) begin
      if (cur_q < eff) begin
        cur_q <= cur_q + 9'd1;
      end else if (cur_q > eff) begin
        cur_q <= cur_q - 9'd1;
      end
    end
  end

  assign cur = cur_q;

endmodule

// File: rtl/pce_audio_mix_sched.sv
// Time-multiplexed stereo mixer: five sources through one shared multiplier,
// accumulated into 19-bit L/R sums and saturated to 16 bits.
module pce_audio_mix_sched
  import pce_audio_pkg::*;
#(
  parameter int FADE_DIV = 4,
  parameter int UNITY    = 256
) (
  input logic clk_sys_42_95,
  input logic reset,
  pce_audio_mix_sched_if.slave bus
);

  localparam logic [7:0] DIV_LAST = 8'(FADE_DIV - 1);

  state_t state_q, state_d;
  logic   out_valid;
  logic   busy;
  logic   accept;
  logic   ramp_step;

  logic [7:0] div_q;
  logic [2:0] slot_q;
  vol_t       cur_vol [3];
  vol_t       vol_snap [3];
  sample_t    smp_q [5];

  sample_t    mul_smp;
  vol_t       mul_vol;
  logic signed [PROD_W-1:0] mul_a, mul_b;
  logic signed [PROD_W-1:0] prod_q;
  logic signed [ACC_W-1:0]  term;
  logic signed [ACC_W-1:0]  acc_l_q, acc_r_q;
  sample_t    sat_l, sat_r;
  sample_t    audio_l_q, audio_r_q;
  logic       overrun_q;

  assign accept    = (state_q == ST_IDLE) && bus.sample_strobe;
  assign ramp_step = accept && (div_q == DIV_LAST);

  // Per-source volume ramps; the select code doubles as the source index.
  for (genvar i = 0; i < 3; i++) begin : g_ramp
    pce_audio_vol_ramp #(.UNITY(UNITY)) u_ramp (
      .clk   (clk_sys_42_95),
      .rst   (reset),
      .we    (bus.vol_we && (bus.vol_sel == 2'(i))),
      .wdata (bus.vol_data),
      .mute  (bus.mute),
      .step  (ramp_step),
      .cur   (cur_vol[i])
    );
  end

  // Ramp divider advances once per accepted strobe and wraps after FADE_DIV.
  always_ff @(posedge clk_sys_42_95 or posedge reset) begin
    if (reset) begin
      div_q <= '0;
    end else if (accept) begin
      div_q <= ramp_step ? 8'd0 : div_q + 8'd1;
    end
  end

  // FSM state register.
  always_ff @(posedge clk_sys_42_95 or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state and status outputs.
  always_comb begin
    state_d   = state_q;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state_q)
      ST_IDLE: begin
        busy = 1'b0;
        if (bus.sample_strobe) state_d = ST_LATCH;
      end
      ST_LATCH: state_d = ST_MUL;
      ST_MUL:   state_d = ST_ACC;
      ST_ACC:   state_d = (slot_q == 3'd4) ? ST_SAT : ST_MUL;
      ST_SAT: begin
        out_valid = 1'b1;
        state_d   = ST_IDLE;
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  // Operand select for the shared multiplier, by slot.
  always_comb begin
    mul_smp = smp_q[0];
    mul_vol = vol_snap[SRC_CDDA];
    case (slot_q)
      3'd0: begin mul_smp = smp_q[0]; mul_vol = vol_snap[SRC_CDDA];  end
      3'd1: begin mul_smp = smp_q[1]; mul_vol = vol_snap[SRC_CDDA];  end
      3'd2: begin mul_smp = smp_q[2]; mul_vol = vol_snap[SRC_ADPCM]; end
      3'd3: begin mul_smp = smp_q[3]; mul_vol = vol_snap[SRC_PSG];   end
      default: begin mul_smp = smp_q[4]; mul_vol = vol_snap[SRC_PSG]; end
    endcase
    mul_a = PROD_W'(mul_smp);
    mul_b = PROD_W'($signed({1'b0, mul_vol}));
    term  = ACC_W'(prod_q >>> 8);
    sat_l = sat16(acc_l_q);
    sat_r = sat16(acc_r_q);
  end

  // Volumes are frozen at acceptance so a ramp step never hits a sample in flight.
  always_ff @(posedge clk_sys_42_95 or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 3; i++) vol_snap[i] <= '0;
    end else if (accept) begin
      for (int i = 0; i < 3; i++) vol_snap[i] <= cur_vol[i];
    end
  end

  // Datapath: latch sources, multiply, accumulate per slot, saturate to outputs.
  always_ff @(posedge clk_sys_42_95 or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 5; i++) smp_q[i] <= '0;
      slot_q    <= '0;
      prod_q    <= '0;
      acc_l_q   <= '0;
      acc_r_q   <= '0;
      audio_l_q <= '0;
      audio_r_q <= '0;
    end else begin
      case (state_q)
        ST_LATCH: begin
          smp_q[0] <= bus.cdda_l;
          smp_q[1] <= bus.cdda_r;
          smp_q[2] <= bus.adpcm;
          smp_q[3] <= bus.psg_l;
          smp_q[4] <= bus.psg_r;
          acc_l_q  <= '0;
          acc_r_q  <= '0;
          slot_q   <= '0;
        end
        ST_MUL: prod_q <= mul_a * mul_b;
        ST_ACC: begin
          case (slot_q)
            3'd0, 3'd3: acc_l_q <= acc_l_q + term;
            3'd1, 3'd4: acc_r_q <= acc_r_q + term;
            default: begin
              acc_l_q <= acc_l_q + term;
              acc_r_q <= acc_r_q + term;
            end
          endcase
          slot_q <= slot_q + 3'd1;
        end
        ST_SAT: begin
          audio_l_q <= sat_l;
          audio_r_q <= sat_r;
        end
        default: ;
      endcase
    end
  end

  // Sticky overrun: any strobe arriving while a sample is in progress.
  always_ff @(posedge clk_sys_42_95 or posedge reset) begin
    if (reset) begin
      overrun_q <= 1'b0;
    end else if (bus.sample_strobe && busy) begin
      overrun_q <= 1'b1;
    end
  end

  // Outputs show the fresh pair during the out_valid cycle, then hold it.
  assign bus.audio_l   = (state_q == ST_SAT) ? sat_l : audio_l_q;
  assign bus.audio_r   = (state_q == ST_SAT) ? sat_r : audio_r_q;
  assign bus.out_valid = out_valid;
  assign bus.busy      = busy;
  assign bus.overrun   = overrun_q;
  assign bus.state     = state_q;

endmodule

// File: tb/tb_pce_audio_mix_sched.sv
// Self-checking bench for pce_audio_mix_sched: directed sequence plus a
// behavioural volume/mix model feeding an expected-result queue.
module tb_pce_audio_mix_sched;
  import pce_audio_pkg::*;

  localparam int FADE_DIV = 4;
  localparam int UNITY    = 256;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  pce_audio_mix_sched_if bus ();

  pce_audio_mix_sched #(.FADE_DIV(FADE_DIV), .UNITY(UNITY)) dut (
    .clk_sys_42_95 (clk),
    .reset         (rst),
    .bus           (bus)
  );

  // ---------------- scoreboard state ----------------
  logic [31:0] exp_q[$];
  logic [31:0] exp_e;
  int total;
  int bad;
  int ov_count;

  int  m_cur [3];
  int  m_tgt [3];
  int  m_div;
  bit  m_mute;

  task automatic chk(input string tag, input int obs, input int expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  function automatic int term(input int x, input int v);
    int p;
    p = x * v;
    return p >>> 8;
  endfunction

  function automatic int clamp16(input int a);
    if (a > 32767) return 32767;
    if (a < -32768) return -32768;
    return a;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_cur[i] = UNITY;
      m_tgt[i] = UNITY;
    end
    m_div = 0;
    exp_q.delete();
  endtask

  // Expected mix for an accepted strobe, then the ramp update it triggers.
  task automatic model_accept(input int cl, input int cr, input int ad,
                              input int pl, input int pr);
    int l, r, eff;
    logic [31:0] lw, rw;
    l = clamp16(term(cl, m_cur[0]) + term(ad, m_cur[1]) + term(pl, m_cur[2]));
    r = clamp16(term(cr, m_cur[0]) + term(ad, m_cur[1]) + term(pr, m_cur[2]));
    lw = l;
    rw = r;
    exp_q.push_back({lw[15:0], rw[15:0]});
    if (m_div == FADE_DIV - 1) begin
      m_div = 0;
      for (int i = 0; i < 3; i++) begin
        eff = m_mute ? 0 : m_tgt[i];
        if (m_cur[i] < eff) m_cur[i]++;
        else if (m_cur[i] > eff) m_cur[i]--;
      end
    end else begin
      m_div++;
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (bus.out_valid === 1'b1) begin
      ov_count++;
      if (exp_q.size() == 0) begin
        chk("unexpected_out_valid", int'(bus.out_valid), 0);
      end else begin
        exp_e = exp_q.pop_front();
        chk("sb_audio_l", int'(bus.audio_l), int'($signed(exp_e[31:16])));
        chk("sb_audio_r", int'(bus.audio_r), int'($signed(exp_e[15:0])));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic apply_reset();
    rst = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic vol_write(input int sel, input int data);
    @(posedge clk);
    #1;
    bus.vol_we   = 1'b1;
    bus.vol_sel  = 2'(sel);
    bus.vol_data = 9'(data);
    if (sel < 3) m_tgt[sel] = (data > UNITY) ? UNITY : data;
    @(posedge clk);
    #1 bus.vol_we = 1'b0;
  endtask

  task automatic set_inputs(input int cl, input int cr, input int ad,
                            input int pl, input int pr);
    bus.cdda_l = 16'(cl);
    bus.cdda_r = 16'(cr);
    bus.adpcm  = 16'(ad);
    bus.psg_l  = 16'(pl);
    bus.psg_r  = 16'(pr);
  endtask

  // One strobe; checks out_valid lands 12 cycles after the strobe cycle.
  task automatic do_sample(input int cl, input int cr, input int ad,
                           input int pl, input int pr);
    int k;
    @(posedge clk);
    #1;
    set_inputs(cl, cr, ad, pl, pr);
    bus.sample_strobe = 1'b1;
    model_accept(cl, cr, ad, pl, pr);
    @(posedge clk);
    #1 bus.sample_strobe = 1'b0;
    k = 1;
    while (bus.out_valid !== 1'b1 && k < 40) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk("latency", k, 12);
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed sequence ----------------
  int c0;
  int k;

  initial begin
    total = 0;
    bad = 0;
    ov_count = 0;
    m_mute = 1'b0;
    bus.sample_strobe = 1'b0;
    bus.vol_we = 1'b0;
    bus.vol_sel = 2'd0;
    bus.vol_data = 9'd0;
    bus.mute = 1'b0;
    set_inputs(0, 0, 0, 0, 0);
    apply_reset();

    // reset state
    chk("rst_audio_l", int'(bus.audio_l), 0);
    chk("rst_audio_r", int'(bus.audio_r), 0);
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_overrun", int'(bus.overrun), 0);
    chk("rst_state", int'(bus.state), int'(ST_IDLE));

    // unity pass-through
    do_sample(1000, 0, 50, -200, 0);
    chk("unity_l", int'(bus.audio_l), 850);
    chk("unity_r", int'(bus.audio_r), 50);

    // saturation both polarities
    do_sample(30000, 0, 30000, 30000, 0);
    chk("sat_pos_l", int'(bus.audio_l), 32767);
    chk("sat_pos_r", int'(bus.audio_r), 30000);
    do_sample(-30000, 0, -30000, -30000, 0);
    chk("sat_neg_l", int'(bus.audio_l), -32768);
    chk("sat_neg_r", int'(bus.audio_r), -30000);

    // random patterns at unity
    for (int i = 0; i < 6; i++) begin
      do_sample(int'($urandom_range(0, 65535)) - 32768,
                int'($urandom_range(0, 65535)) - 32768,
                int'($urandom_range(0, 65535)) - 32768,
                int'($urandom_range(0, 65535)) - 32768,
                int'($urandom_range(0, 65535)) - 32768);
    end

    // volume scaling: ADPCM to 128, CDDA write of 300 clamps to unity, sel 3 ignored
    vol_write(1, 128);
    vol_write(0, 300);
    vol_write(3, 10);
    for (int i = 0; i < FADE_DIV * 128 + 4; i++) begin
      do_sample(2000, 0, 1000, 0, 0);
    end
    chk("vol_settle_l", int'(bus.audio_l), 2500);
    chk("vol_settle_r", int'(bus.audio_r), 500);

    // mute fade out and back in
    apply_reset();
    bus.mute = 1'b1;
    m_mute = 1'b1;
    for (int i = 0; i < 1028; i++) do_sample(1000, -1000, 500, 300, -300);
    chk("mute_l", int'(bus.audio_l), 0);
    chk("mute_r", int'(bus.audio_r), 0);
    bus.mute = 1'b0;
    m_mute = 1'b0;
    for (int i = 0; i < 1028; i++) do_sample(1000, -1000, 500, 300, -300);
    chk("unmute_l", int'(bus.audio_l), 1800);
    chk("unmute_r", int'(bus.audio_r), -800);

    // overrun: strobe at cycle 0 and cycle 5, then accepted strobe at cycle 13
    chk("ovr_pre", int'(bus.overrun), 0);
    c0 = ov_count;
    @(posedge clk);
    #1;
    set_inputs(1234, -4321, 10, 20, 30);
    bus.sample_strobe = 1'b1;
    model_accept(1234, -4321, 10, 20, 30);
    @(posedge clk);
    #1 bus.sample_strobe = 1'b0;
    repeat (4) @(posedge clk);
    #1 bus.sample_strobe = 1'b1;
    @(posedge clk);
    #1 bus.sample_strobe = 1'b0;
    chk("ovr_set", int'(bus.overrun), 1);
    chk("ovr_busy", int'(bus.busy), 1);
    repeat (6) @(posedge clk);
    #1;
    chk("ovr_valid_c12", int'(bus.out_valid), 1);
    @(posedge clk);
    #1;
    chk("ovr_single_valid", ov_count, c0 + 1);
    chk("ovr_sticky", int'(bus.overrun), 1);
    set_inputs(-500, 700, 0, 0, 0);
    bus.sample_strobe = 1'b1;
    model_accept(-500, 700, 0, 0, 0);
    @(posedge clk);
    #1 bus.sample_strobe = 1'b0;
    chk("ovr_c13_accept", int'(bus.busy), 1);
    k = 1;
    while (bus.out_valid !== 1'b1 && k < 40) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk("ovr_c13_latency", k, 12);
    @(posedge clk);
    #1;
    chk("ovr_still", int'(bus.overrun), 1);

    // reset mid-sequence
    @(posedge clk);
    #1;
    set_inputs(111, 222, 333, 444, 555);
    bus.sample_strobe = 1'b1;
    @(posedge clk);
    #1 bus.sample_strobe = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    model_reset();
    c0 = ov_count;
    #1;
    chk("midrst_busy", int'(bus.busy), 0);
    chk("midrst_l", int'(bus.audio_l), 0);
    chk("midrst_r", int'(bus.audio_r), 0);
    chk("midrst_valid", int'(bus.out_valid), 0);
    chk("midrst_overrun", int'(bus.overrun), 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    chk("midrst_no_valid", ov_count, c0);
    do_sample(111, 222, 333, 444, 555);
    chk("post_rst_l", int'(bus.audio_l), 888);
    chk("post_rst_r", int'(bus.audio_r), 1110);

    chk("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pce_audio_mix_sched.md
Name: pce_audio_mix_sched

Overview:
- Time-multiplexed audio mixer scheduler for the PC Engine audio path, clocked on clk_sys_42_95.
- On each output sample strobe it latches the CDDA L/R, ADPCM and PSG L/R samples and walks them through one shared signed multiplier with per-source volume.
- It accumulates and saturates the result to a 16-bit stereo pair.
- It also owns the per-source volume ramps, for click-free fades and mute.

Parameters:
- FADE_DIV, 4: number of sample strobes per one-LSB volume ramp step (1..255).
- UNITY, 256: volume value meaning gain 1.0. This is also the max volume and the reset volume.

Ports:
- clk_sys_42_95  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- sample_strobe  in  1  one-cycle pulse requesting a new output sample
- cdda_l  in  16  signed CDDA left
- cdda_r  in  16  signed CDDA right
- adpcm  in  16  signed ADPCM, mono
- psg_l  in  16  signed PSG left
- psg_r  in  16  signed PSG right
- vol_we  in  1  volume target write strobe
- vol_sel  in  2  target select: 0=CDDA, 1=ADPCM, 2=PSG, 3=ignored
- vol_data  in  9  unsigned target volume
- mute  in  1  level; while high, all effective targets are 0
- audio_l  out  16  signed mixed left
- audio_r  out  16  signed mixed right
- out_valid  out  1  one-cycle pulse when audio_l/audio_r update
- busy  out  1  high from strobe acceptance until out_valid
- overrun  out  1  sticky; set when a strobe arrives while busy

Behaviour:
- Reset is asynchronous, active-high:
  - Outputs: audio_l=audio_r=0, out_valid=0, busy=0, overrun=0.
  - Volumes: cur_vol[0..2]=UNITY, tgt_vol[0..2]=UNITY.
  - Ramp divider=0. FSM=IDLE.
  - Reset mid-sequence aborts the sequence; no out_valid is produced.
- Volume write: when vol_we is high and vol_sel<3, tgt_vol[sel] <= min(vol_data, UNITY). Takes effect next cycle.
- Ramp:
  - Evaluated on each accepted strobe, in the cycle of acceptance.
  - The divider counts 0..FADE_DIV-1. When it wraps, each cur_vol moves 1 toward its effective target, where effective target = mute ? 0 : tgt_vol.
  - The new cur_vol is used from the next sample onward. A sample in progress always uses the values latched at acceptance.
- FSM states are IDLE, LATCH, MUL, ACC, SAT.
  - IDLE: when sample_strobe is high, go to LATCH and set busy=1.
  - LATCH: snapshot the 5 samples and 3 cur_vols; clear accL and accR; set slot=0.
  - MUL: register product = sample[slot] (signed 16) * vol (unsigned 9, zero-extended) as 26-bit signed.
  - ACC: term = product >>> 8 (arithmetic), sign-extended to 19 bits.
    - Slot mapping: 0 cdda_l->accL; 1 cdda_r->accR; 2 adpcm->accL and accR; 3 psg_l->accL; 4 psg_r->accR.
    - If slot==4, go to SAT; otherwise increment slot and go to MUL.
  - SAT: clamp accL and accR to [-32768, 32767] into audio_l/audio_r. Pulse out_valid=1. Clear busy. Go to IDLE.
- Latency: a strobe in cycle 0 gives out_valid in cycle 12. The sequence is 1 LATCH, then 5×(MUL+ACC), then SAT. audio_l/audio_r hold their value between updates.
- A strobe while busy=1, including in the SAT cycle, is dropped and sets overrun. A strobe in the cycle after SAT is accepted.
- Accumulator range: worst case is 3×32768 per channel, which fits in 19-bit signed, so no intermediate wrap is possible.
- vol=UNITY gives an exact pass-through: x*256>>>8 = x.

Decomposition:
- Shared package pce_audio_pkg:
  - Typedef for the 16-bit signed sample.
  - Typedef for the 9-bit volume.
  - Source index enum: SRC_CDDA=0, SRC_ADPCM=1, SRC_PSG=2.
  - Constant for the saturation bounds.
- Sub-module pce_audio_vol_ramp, instantiated 3×: holds the target and current volume and steps on an enable input. The FSM, multiplier and accumulators stay in the top module.

Test Plan:
- Unity pass-through:
  - Stimulus: after reset, cdda_l=1000, psg_l=-200, adpcm=50, others 0; pulse sample_strobe.
  - Required: out_valid exactly 12 cycles later; audio_l=850, audio_r=50.
- Saturation:
  - Stimulus: cdda_l=psg_l=adpcm=30000 at unity; strobe.
  - Required: audio_l=32767. Repeat with -30000 each: audio_l=-32768.
- Volume scaling:
  - Stimulus: write ADPCM volume vol_data=128 and CDDA volume 300 (clamps to 256). Run FADE_DIV×128 strobes with adpcm=1000.
  - Required: ADPCM contribution steps down 1 LSB-volume every 4 strobes and settles at 500. CDDA is unchanged.
- Mute fade:
  - Stimulus: assert mute with all volumes at 256 and FADE_DIV=4.
  - Required: after 1024 strobes, outputs are 0. Deassert mute: volumes ramp back, reaching 256 after a further 1024 strobes.
- Overrun:
  - Stimulus: strobe at cycle 0 and again at cycle 5.
  - Required: second strobe ignored; single out_valid at cycle 12; overrun=1 and stays 1.
  - Stimulus: strobe at cycle 13.
  - Required: accepted.
- Reset mid-operation:
  - Stimulus: assert reset at cycle 6 after a strobe.
  - Required: immediately busy=0, audio_l=audio_r=0, no out_valid. The first strobe after release produces a normal output 12 cycles later.
